// File: rtl/prm_com_filter.sv
// Command conditioning after the PRM receiver: 2-flop sync, per-channel
// confirm filter, minimum on-time, and immediate release on terminal disable.
module prm_com_filter #(
  parameter int WIDTH   = 16,
  parameter int CONFIRM = 4,
  parameter int HOLD    = 8
) (
  input  logic             iClk,
  input  logic             iRes,
  input  logic [WIDTH-1:0] iCom,
  input  logic             iEnable,
  output logic [WIDTH-1:0] oCom,
  output logic             oAny
);

  localparam int MAXV = (CONFIRM > HOLD) ? CONFIRM : HOLD;
  localparam int CW   = $clog2(MAXV + 1);

  localparam logic [CW-1:0] C_ZERO      = '0;
  localparam logic [CW-1:0] C_ONE       = CW'(1);
  localparam logic [CW-1:0] C_CONF_LAST = CW'(CONFIRM - 1);
  localparam logic [CW-1:0] C_HOLD      = CW'(HOLD);

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_ARM = 2'd1,
    ST_ON  = 2'd2
  } state_t;

  logic [WIDTH-1:0] r_comMeta;
  logic [WIDTH-1:0] r_comSync;
  logic             r_enMeta;
  logic             r_enSync;
  logic [WIDTH-1:0] w_on;

  // Inputs are inverted before synchronising so that 1 means requested/enabled.
  always_ff @(posedge iClk or negedge iRes) begin
    if (!iRes) begin
      r_comMeta <= '0;
      r_comSync <= '0;
      r_enMeta  <= 1'b0;
      r_enSync  <= 1'b0;
    end else begin
      r_comMeta <= ~iCom;
      r_comSync <= r_comMeta;
      r_enMeta  <= ~iEnable;
      r_enSync  <= r_enMeta;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_t        r_state;
    logic [CW-1:0] r_cnt;

    // cnt counts confirm samples in ARM and elapsed on-time in ON.
    always_ff @(posedge iClk or negedge iRes) begin
      if (!iRes) begin
        r_state <= ST_OFF;
        r_cnt   <= C_ZERO;
      end else if (!r_enSync) begin
        r_state <= ST_OFF;
        r_cnt   <= C_ZERO;
      end else begin
        case (r_state)
          ST_OFF: begin
            if (r_comSync[i]) begin
              r_state <= ST_ARM;
              r_cnt   <= C_ONE;
            end else begin
              r_cnt   <= C_ZERO;
            end
          end
          ST_ARM: begin
            if (!r_comSync[i]) begin
              r_state <= ST_OFF;
              r_cnt   <= C_ZERO;
            end else if (r_cnt == C_CONF_LAST) begin
              r_state <= ST_ON;
              r_cnt   <= C_ONE;
            end else begin
              r_cnt   <= r_cnt + C_ONE;
            end
          end
          ST_ON: begin
            if (!r_comSync[i] && (r_cnt >= C_HOLD)) begin
              r_state <= ST_OFF;
              r_cnt   <= C_ZERO;
            end else if (r_cnt < C_HOLD) begin
              r_cnt   <= r_cnt + C_ONE;
            end
          end
          default: begin
            r_state <= ST_OFF;
            r_cnt   <= C_ZERO;
          end
        endcase
      end
    end

    assign w_on[i] = (r_state == ST_ON);
  end

  // Raw iEnable gates the drivers so a disable releases without any clock.
  assign oCom = ~(w_on & {WIDTH{~iEnable}});
  assign oAny = |w_on;

endmodule

// File: tb/tb_prm_com_filter.sv
// Self-checking bench for prm_com_filter: cycle-by-cycle behavioural model
// plus directed scenarios with hand-computed expectations.
module tb_prm_com_filter;

  localparam int WIDTH   = 16;
  localparam int CONFIRM = 4;
  localparam int HOLD    = 8;

  logic             iClk = 1'b0;
  logic             iRes = 1'b0;
  logic [WIDTH-1:0] iCom = '0;
  logic             iEnable = 1'b0;
  logic [WIDTH-1:0] oCom;
  logic             oAny;

  int checks = 0;
  int errors = 0;

  prm_com_filter #(
    .WIDTH  (WIDTH),
    .CONFIRM(CONFIRM),
    .HOLD   (HOLD)
  ) dut (
    .iClk   (iClk),
    .iRes   (iRes),
    .iCom   (iCom),
    .iEnable(iEnable),
    .oCom   (oCom),
    .oAny   (oAny)
  );

  initial forever #5 iClk = ~iClk;

  // Model: a channel turns on once it has seen CONFIRM consecutive
  // synchronised requests while enabled, and may turn off only when the
  // request is gone and at least HOLD edges have passed since turn-on.
  logic [WIDTH-1:0] mMeta = '0;
  logic [WIDTH-1:0] mSync = '0;
  logic             mEnMeta = 1'b0;
  logic             mEnSync = 1'b0;
  bit               mOn[WIDTH];
  int               mRun[WIDTH];
  int               mOnEdge[WIDTH];
  int               mEdge = 0;

  always @(posedge iClk or negedge iRes) begin
    if (!iRes) begin
      mMeta   = '0;
      mSync   = '0;
      mEnMeta = 1'b0;
      mEnSync = 1'b0;
      mEdge   = 0;
      for (int i = 0; i < WIDTH; i++) begin
        mOn[i]     = 1'b0;
        mRun[i]    = 0;
        mOnEdge[i] = 0;
      end
    end else begin
      mEdge++;
      for (int i = 0; i < WIDTH; i++) begin
        if (!mEnSync) begin
          mOn[i]  = 1'b0;
          mRun[i] = 0;
        end else begin
          if (mSync[i]) mRun[i]++;
          else          mRun[i] = 0;
          if (mOn[i]) begin
            if (!mSync[i] && (mEdge - mOnEdge[i] >= HOLD)) mOn[i] = 1'b0;
          end else if (mRun[i] >= CONFIRM) begin
            mOn[i]     = 1'b1;
            mOnEdge[i] = mEdge;
          end
        end
      end
      mEnSync = mEnMeta;
      mEnMeta = ~iEnable;
      mSync   = mMeta;
      mMeta   = ~iCom;
    end
  end

  // Every falling edge, the DUT outputs must match the model.
  always @(negedge iClk) begin
    logic [WIDTH-1:0] onVec;
    logic [WIDTH-1:0] expCom;
    logic             expAny;
    for (int i = 0; i < WIDTH; i++) onVec[i] = mOn[i];
    expCom = ~(onVec & {WIDTH{~iEnable}});
    expAny = |onVec;
    checks++;
    if (oCom !== expCom || oAny !== expAny) begin
      errors++;
      $display("[TB] FAIL model t=%0t oCom=%h oAny=%b expected oCom=%h oAny=%b",
               $time, oCom, oAny, expCom, expAny);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge iClk);
    #2;
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] com, input logic en);
    iCom    = com;
    iEnable = en;
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] expCom,
                             input logic expAny);
    checks++;
    if (oCom !== expCom || oAny !== expAny) begin
      errors++;
      $display("[TB] FAIL %s oCom=%h oAny=%b expected oCom=%h oAny=%b",
               name, oCom, oAny, expCom, expAny);
    end
  endtask

  initial begin
    // Reset held with everything requested and enabled.
    applyStimulus(16'h0000, 1'b0);
    iRes = 1'b0;
    tick(3);
    checkOutput("resetHold", 16'hFFFF, 1'b0);
    iRes = 1'b1;
    tick(5);
    checkOutput("resetPreConfirm", 16'hFFFF, 1'b0);
    tick(1);
    checkOutput("resetTurnOn", 16'h0000, 1'b1);
    applyStimulus(16'hFFFF, 1'b0);
    tick(12);
    checkOutput("idleAfterReset", 16'hFFFF, 1'b0);

    // Confirm filter: 3 samples rejected, 4 samples accepted with HOLD on-time.
    applyStimulus(16'hFFFE, 1'b0);
    tick(3);
    applyStimulus(16'hFFFF, 1'b0);
    tick(10);
    checkOutput("shortPulse", 16'hFFFF, 1'b0);
    applyStimulus(16'hFFFE, 1'b0);
    tick(4);
    applyStimulus(16'hFFFF, 1'b0);
    tick(1);
    checkOutput("pulse4PreOn", 16'hFFFF, 1'b0);
    tick(1);
    checkOutput("pulse4On", 16'hFFFE, 1'b1);
    tick(7);
    checkOutput("pulse4HoldLast", 16'hFFFE, 1'b1);
    tick(1);
    checkOutput("pulse4HoldEnd", 16'hFFFF, 1'b0);
    tick(4);

    // Long command.
    applyStimulus(16'h5AA5, 1'b0);
    tick(5);
    checkOutput("longPreOn", 16'hFFFF, 1'b0);
    tick(1);
    checkOutput("longOn", 16'h5AA5, 1'b1);
    tick(44);
    checkOutput("longHeld", 16'h5AA5, 1'b1);
    applyStimulus(16'hFFFF, 1'b0);
    tick(2);
    checkOutput("longRelease2", 16'h5AA5, 1'b1);
    tick(1);
    checkOutput("longRelease3", 16'hFFFF, 1'b0);
    tick(4);

    // Hold re-trigger on bit 3.
    applyStimulus(16'hFFF7, 1'b0);
    tick(6);
    checkOutput("retrigOn", 16'hFFF7, 1'b1);
    tick(2);
    applyStimulus(16'hFFFF, 1'b0);
    tick(1);
    checkOutput("retrigDrop1", 16'hFFF7, 1'b1);
    tick(1);
    checkOutput("retrigDrop2", 16'hFFF7, 1'b1);
    applyStimulus(16'hFFF7, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      checkOutput("retrigHeld", 16'hFFF7, 1'b1);
    end
    applyStimulus(16'hFFFF, 1'b0);
    tick(3);
    checkOutput("retrigRelease", 16'hFFFF, 1'b0);
    tick(2);

    // Enable withdrawal and re-confirmation.
    applyStimulus(16'h0F0F, 1'b0);
    tick(6);
    checkOutput("enOn", 16'h0F0F, 1'b1);
    applyStimulus(16'h0F0F, 1'b1);
    #1;
    checkOutput("enDropComb", 16'hFFFF, 1'b1);
    tick(3);
    checkOutput("enDropCleared", 16'hFFFF, 1'b0);
    tick(3);
    applyStimulus(16'h0F0F, 1'b0);
    tick(5);
    checkOutput("enReconfirmPre", 16'hFFFF, 1'b0);
    tick(1);
    checkOutput("enReconfirmOn", 16'h0F0F, 1'b1);
    applyStimulus(16'hFFFF, 1'b0);
    tick(12);
    checkOutput("enIdle", 16'hFFFF, 1'b0);

    // Reset in the middle of the hold.
    applyStimulus(16'hFFFE, 1'b0);
    tick(6);
    checkOutput("midHoldOn", 16'hFFFE, 1'b1);
    tick(1);
    iRes = 1'b0;
    #1;
    checkOutput("midHoldReset", 16'hFFFF, 1'b0);
    applyStimulus(16'hFFFF, 1'b0);
    tick(2);
    iRes = 1'b1;
    tick(12);
    checkOutput("midHoldAfter", 16'hFFFF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
